// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative MULT/MULTU/DIV/DIVU unit for the EXE stage.
// Config: define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module exe_muldiv (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] m_q, m_d;
    logic [63:0] acc_q, acc_d;
    logic        neg_q, neg_d;
    logic        rsign_q, rsign_d;
    logic        bzero_q, bzero_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        accept;
    logic [32:0] rem_sh, rem_sub;
    logic        rem_ge;
    logic [63:0] div_nxt;
    logic [63:0] mul_nxt;
    logic [63:0] prod_fin;
    logic [32:0] mul_sum;

    // Operand magnitudes and the start-acceptance / stall decode.
    always_comb begin
        a_neg  = ~op[0] & src_a[31];
        b_neg  = ~op[0] & src_b[31];
        a_mag  = a_neg ? -src_a : src_a;
        b_mag  = b_neg ? -src_b : src_b;
        accept = start & ~flush &
                 ((state_q == S_IDLE) | (state_q == S_DONE));
        busy   = ~rst & (accept | (state_q == S_MUL) |
                         (state_q == S_DIV));
        done   = (state_q == S_DONE);
        hi     = hi_q;
        lo     = lo_q;
    end

    // One restoring-division step: acc holds {remainder, dividend/quotient}.
    always_comb begin
        rem_sh  = {acc_q[63:32], acc_q[31]};
        rem_ge  = (rem_sh >= {1'b0, m_q});
        rem_sub = rem_sh - {1'b0, m_q};
        div_nxt = {(rem_ge ? rem_sub[31:0] : rem_sh[31:0]),
                   acc_q[30:0], rem_ge};
    end

    // Multiply datapath: shift-add step, or a full product when fast.
    always_comb begin
        mul_sum = 33'd0;
`ifdef MULDIV_FAST_MUL_EN
        mul_nxt = 64'(m_q) * 64'(acc_q[31:0]);
`else
        mul_sum = {1'b0, acc_q[63:32]} +
                  (acc_q[0] ? {1'b0, m_q} : 33'd0);
        mul_nxt = {mul_sum, acc_q[31:1]};
`endif
        prod_fin = neg_q ? -mul_nxt : mul_nxt;
    end

    // Next-state, operand capture and result capture on entry to DONE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        m_d     = m_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        rsign_d = rsign_q;
        bzero_d = bzero_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    cnt_d   = 5'd0;
                    neg_d   = a_neg ^ b_neg;
                    rsign_d = a_neg;
                    bzero_d = (src_b == 32'd0);
                    if (op[1]) begin
                        state_d = S_DIV;
                        m_d     = b_mag;
                        acc_d   = {32'd0, a_mag};
                    end else begin
                        state_d = S_MUL;
                        m_d     = a_mag;
                        acc_d   = {32'd0, b_mag};
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MUL: begin
                acc_d = mul_nxt;
                cnt_d = cnt_q + 5'd1;
`ifdef MULDIV_FAST_MUL_EN
                state_d = S_DONE;
                hi_d    = prod_fin[63:32];
                lo_d    = prod_fin[31:0];
`else
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    hi_d    = prod_fin[63:32];
                    lo_d    = prod_fin[31:0];
                end
`endif
            end
            S_DIV: begin
                acc_d = div_nxt;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = S_DONE;
                    hi_d    = rsign_q ? -div_nxt[63:32] : div_nxt[63:32];
                    if (bzero_q)
                        lo_d = 32'hFFFF_FFFF;
                    else
                        lo_d = neg_q ? -div_nxt[31:0] : div_nxt[31:0];
                end
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            m_q     <= 32'd0;
            acc_q   <= 64'd0;
            neg_q   <= 1'b0;
            rsign_q <= 1'b0;
            bzero_q <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            rsign_q <= rsign_d;
            bzero_q <= bzero_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: randomized and directed bench for exe_muldiv
// against a plain-arithmetic reference of the HI/LO results.
module tb_exe_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad = 0;
    logic [31:0] last_hi = 32'd0;
    logic [31:0] last_lo = 32'd0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    exe_muldiv dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // Expected {hi, lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] r;
        longint sa, sb, q, m;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        q = 0;
        m = 0;
        case (o)
            2'd0: r = 64'(sa * sb);
            2'd1: r = ua * ub;
            2'd2: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 32'd0)
                    r = {a, 32'hFFFF_FFFF};
                else
                    r = {a % b, a / b};
            end
        endcase
        return r;
    endfunction

    // Launch at the current negedge; returns in the done cycle.
    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input bit noise);
        int lat;
        bit got;
        logic [63:0] exp;
        lat = o[1] ? DIV_LAT : MUL_LAT;
        exp = model(o, a, b);
        start = 1'b1;
        op = o;
        src_a = a;
        src_b = b;
        #1;
        chk({tag, "_busy0"}, 64'(busy), 64'd1);
        got = 1'b0;
        for (int n = 1; n <= lat + 3 && !got; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (noise && n == 5) begin
                start = 1'b1;
                op = 2'($urandom);
                src_a = $urandom;
                src_b = $urandom;
            end
            #1;
            if (done) begin
                got = 1'b1;
                chk({tag, "_lat"}, 64'(n), 64'(lat));
                chk({tag, "_busydn"}, 64'(busy), 64'd0);
                chk({tag, "_hilo"}, {hi, lo}, exp);
                last_hi = exp[63:32];
                last_lo = exp[31:0];
            end else if (n < lat && !busy) begin
                chk({tag, "_busy"}, 64'(busy), 64'd1);
            end
        end
        start = 1'b0;
        if (!got)
            chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int pulses;
        #2;
        chk("rst_out", {30'd0, busy, done, hi, lo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("mult", 2'd0, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        @(negedge clk);
        run_op("divu", 2'd3, 32'd100, 32'd7, 1'b0);
        chk("divu_const", {hi, lo}, {32'd2, 32'd14});
        @(negedge clk);
        run_op("div", 2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        @(negedge clk);
        run_op("divu0", 2'd3, 32'h1234, 32'd0, 1'b0);
        chk("divu0_const", {hi, lo}, {32'h1234, 32'hFFFF_FFFF});
        @(negedge clk);
        run_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});
        @(negedge clk);
        run_op("div0s", 2'd2, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op("multu", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);

        // Back-to-back: second start presented in the done cycle.
        @(negedge clk);
        run_op("b2b_a", 2'd3, 32'd1000, 32'd3, 1'b0);
        run_op("b2b_b", 2'd2, 32'hFFFF_F000, 32'd7, 1'b1);

        // Flush wins over start in the same cycle.
        start = 1'b1;
        flush = 1'b1;
        op = 2'd2;
        src_a = 32'd9;
        src_b = 32'd2;
        #1;
        chk("prio_busy", 64'(busy), 64'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("prio_after", {62'd0, busy, done}, 64'd0);

        // Flush mid-divide.
        @(negedge clk);
        start = 1'b1;
        op = 2'd2;
        src_a = 32'h7654_3210;
        src_b = 32'd13;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start = 1'b0;
            flush = (n == 10);
        end
        #1;
        chk("fl_idle", {62'd0, busy, done}, 64'd0);
        pulses = 0;
        repeat (36) begin
            @(negedge clk);
            #1;
            if (done) pulses++;
        end
        chk("fl_nodone", 64'(pulses), 64'd0);
        chk("fl_hold", {hi, lo}, {last_hi, last_lo});

        // Randomized operations with random idle gaps.
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom);
            ra = pick();
            rb = pick();
            if ($urandom_range(0, 1) == 1)
                @(negedge clk);
            run_op("rnd", ro, ra, rb, bit'($urandom_range(0, 1)));
        end

        // Asynchronous reset mid-divide.
        @(negedge clk);
        start = 1'b1;
        op = 2'd3;
        src_a = 32'hDEAD_BEEF;
        src_b = 32'd3;
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out", {30'd0, busy, done, hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("post_rst", 2'd3, 32'hDEAD_BEEF, 32'd3, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
